// File: rtl/wbc_vec_fetch.sv
// wbc_vec_fetch: CPU-side interrupt vector fetch sequencer.
// Raises a vector strobe toward the interrupt controller when an interrupt
// is requested at an interruptible point, latches and alignment-checks the
// returned vector, holds it for the core until consumed, then enforces a
// guard interval so the controller can re-arbitrate. A missing acknowledge
// is bounded by a timeout that delivers a fallback vector flagged as error.
module wbc_vec_fetch #(
    parameter int          TIMEOUT = 16,
    parameter int          GUARD   = 2,
    parameter logic [15:0] ERR_VEC = 16'o000004
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        vic_irq_i,
    output logic        vic_stb_o,
    input  logic        vic_ack_i,
    input  logic [15:0] vic_dat_i,
    input  logic        cpu_ien_i,
    output logic [15:0] vec_o,
    output logic        vec_valid_o,
    output logic        vec_err_o,
    input  logic        vec_taken_i,
    output logic        busy_o
);

    // Timeout counter holds 0..TIMEOUT-1, guard counter holds 0..GUARD.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD);
    localparam logic [GW-1:0] GUARD_LAST = GW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_GUARD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic            stb_q, stb_d;
    logic [15:0]     vec_q, vec_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    // Next-state and next-output computation for the fetch sequence.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        stb_d   = stb_q;
        vec_d   = vec_q;
        valid_d = valid_q;
        err_d   = err_q;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (vic_irq_i && cpu_ien_i) begin
                    state_d = S_REQ;
                    stb_d   = 1'b1;
                    busy_d  = 1'b1;
                    tcnt_d  = '0;
                end
            end

            S_REQ: begin
                // Ack takes priority over an expiring timeout on the same cycle.
                if (vic_ack_i) begin
                    state_d = S_HOLD;
                    vec_d   = {vic_dat_i[15:2], 2'b00};
                    err_d   = |vic_dat_i[1:0];
                    stb_d   = 1'b0;
                    valid_d = 1'b1;
                end else if (tcnt_q == TO_LAST) begin
                    state_d = S_HOLD;
                    vec_d   = ERR_VEC;
                    err_d   = 1'b1;
                    stb_d   = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end

            S_HOLD: begin
                if (vec_taken_i) begin
                    state_d = S_GUARD;
                    valid_d = 1'b0;
                    gcnt_d  = GUARD_LOAD;
                end
            end

            S_GUARD: begin
                // Strobe stays low here so the controller can re-latch its winner.
                if (gcnt_q <= GUARD_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                stb_d   = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any pending vector.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            stb_q   <= 1'b0;
            vec_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            stb_q   <= stb_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign vic_stb_o   = stb_q;
    assign vec_o       = vec_q;
    assign vec_valid_o = valid_q;
    assign vec_err_o   = err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_wbc_vec_fetch.sv
// Directed bench for wbc_vec_fetch: expected vectors are queued when the
// controller side is driven (or a timeout is due) and compared when the
// sequencer presents vec_valid_o.
module tb_wbc_vec_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq;
    logic        stb;
    logic        ack;
    logic [15:0] dat;
    logic        ien;
    logic [15:0] vec;
    logic        vld;
    logic        err;
    logic        taken;
    logic        busy;

    int passed = 0;
    int total  = 0;

    logic [16:0] exp_q[$];

    wbc_vec_fetch #(
        .TIMEOUT(16),
        .GUARD  (2),
        .ERR_VEC(16'o000004)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .vic_irq_i  (irq),
        .vic_stb_o  (stb),
        .vic_ack_i  (ack),
        .vic_dat_i  (dat),
        .cpu_ien_i  (ien),
        .vec_o      (vec),
        .vec_valid_o(vld),
        .vec_err_o  (err),
        .vec_taken_i(taken),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Pop the oldest expected vector and compare against the presented one.
    task automatic chk_vec(input string tag);
        logic [16:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(vld), 32'd1);
            chk({tag, "_vec"}, 32'(vec), 32'(e[15:0]));
            chk({tag, "_err"}, 32'(err), 32'(e[16]));
        end
    endtask

    initial begin
        rst = 1'b1; irq = 1'b0; ack = 1'b0; dat = '0; ien = 1'b0; taken = 1'b0;
        step();
        step();
        chk("rst_stb", 32'(stb), 0);
        chk("rst_vec", 32'(vec), 0);
        chk("rst_valid", 32'(vld), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();
        chk("idle_stb", 32'(stb), 0);

        // Nominal fetch: ack two cycles after the strobe rises.
        irq = 1'b1; ien = 1'b1;
        step();
        chk("nom_stb_rise", 32'(stb), 1);
        chk("nom_busy", 32'(busy), 1);
        step();
        chk("nom_stb_hold", 32'(stb), 1);
        chk("nom_valid_low", 32'(vld), 0);
        ack = 1'b1; dat = 16'o000060;
        exp_q.push_back({1'b0, 16'o000060});
        step();
        ack = 1'b0; dat = '0;
        chk("nom_stb_fall", 32'(stb), 0);
        chk_vec("nom");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nom_hold_valid", 32'(vld), 1);
            chk("nom_hold_vec", 32'(vec), 32'(16'o000060));
        end
        taken = 1'b1;
        step();
        taken = 1'b0;
        chk("nom_taken_valid", 32'(vld), 0);
        chk("nom_guard_busy0", 32'(busy), 1);
        step();
        chk("nom_guard_busy1", 32'(busy), 1);
        chk("nom_guard_stb1", 32'(stb), 0);
        step();
        chk("nom_idle_busy", 32'(busy), 0);
        chk("nom_idle_stb", 32'(stb), 0);
        step();
        chk("nom_restrobe", 32'(stb), 1);

        // Timeout: irq drop is ignored, strobe high exactly 16 cycles.
        irq = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            chk("to_stb_high", 32'(stb), 1);
            chk("to_valid_low", 32'(vld), 0);
        end
        exp_q.push_back({1'b1, 16'o000004});
        step();
        chk("to_stb_fall", 32'(stb), 0);
        chk_vec("to");
        ack = 1'b1; dat = 16'o000100;
        step();
        ack = 1'b0; dat = '0;
        chk("to_late_ack_vec", 32'(vec), 32'(16'o000004));
        chk("to_late_ack_err", 32'(err), 1);
        chk("to_late_ack_valid", 32'(vld), 1);
        taken = 1'b1;
        step();
        taken = 1'b0;
        step();
        step();
        chk("to_back_idle", 32'(busy), 0);

        // Masked: irq high, ien low keeps the block idle.
        irq = 1'b1; ien = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mask_stb", 32'(stb), 0);
            chk("mask_busy", 32'(busy), 0);
        end
        ien = 1'b1;
        step();
        chk("mask_release_stb", 32'(stb), 1);

        // Misaligned vector: low bits cleared, error flagged.
        step();
        ack = 1'b1; dat = 16'o000063;
        exp_q.push_back({1'b1, 16'o000060});
        step();
        ack = 1'b0; dat = '0;
        chk("mis_stb_fall", 32'(stb), 0);
        chk_vec("mis");

        // Hold with taken low and irq high: stable vector, no strobe.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_stb", 32'(stb), 0);
            chk("hold_vec", 32'(vec), 32'(16'o000060));
            chk("hold_valid", 32'(vld), 1);
        end
        taken = 1'b1;
        step();
        taken = 1'b0;
        chk("grd_stb0", 32'(stb), 0);
        step();
        chk("grd_stb1", 32'(stb), 0);
        step();
        chk("grd_stb2", 32'(stb), 0);
        step();
        chk("grd_restrobe", 32'(stb), 1);

        // Ack landing on the final timeout cycle wins.
        for (int i = 1; i < 16; i++) step();
        chk("last_stb_high", 32'(stb), 1);
        ack = 1'b1; dat = 16'o000100;
        exp_q.push_back({1'b0, 16'o000100});
        step();
        ack = 1'b0; dat = '0;
        chk("last_stb_fall", 32'(stb), 0);
        chk_vec("last");
        taken = 1'b1; ien = 1'b0;
        step();
        taken = 1'b0;
        step();
        step();
        step();
        chk("last_idle_busy", 32'(busy), 0);

        // Reset in the middle of a request.
        ien = 1'b1;
        step();
        chk("mid_stb", 32'(stb), 1);
        rst = 1'b1;
        step();
        chk("mid_rst_stb", 32'(stb), 0);
        chk("mid_rst_valid", 32'(vld), 0);
        chk("mid_rst_vec", 32'(vec), 0);
        chk("mid_rst_err", 32'(err), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();
        chk("mid_post_stb", 32'(stb), 1);
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
